// File: rtl/interval_timer.sv
// Programmable interval timer: CTRL/PRESET/COUNT register window, one-shot or
// auto-reload down-counter, level interrupt gated by IM.
module interval_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic        im_r;
  logic        im_next_s;
  logic [1:0]  mode_r;
  logic [1:0]  mode_next_s;
  logic        en_r;
  logic        en_next_s;
  logic [31:0] preset_r;
  logic [31:0] preset_next_s;
  logic [31:0] count_r;
  logic [31:0] count_next_s;
  logic        pending_r;
  logic        pending_next_s;

  logic        ctrl_wr_s;
  logic        preset_wr_s;
  logic        reload_mode_s;
  logic        cnt_en_s;
  logic        expire_s;

  assign ctrl_wr_s     = we && (addr == ADDR_CTRL);
  assign preset_wr_s   = we && (addr == ADDR_PRESET);
  assign reload_mode_s = (mode_r == MODE_RELOAD);
  // A CTRL write landing during CNT takes effect at the same edge, so a
  // disable written on the final count beats the transition into INT.
  assign cnt_en_s      = ctrl_wr_s ? din[0] : en_r;
  assign expire_s      = (state_r == CNT) && cnt_en_s && (count_r <= 32'd1);

  // Next state and next COUNT; COUNT <= 1 saturates to 0 so PRESET=0 acts as 1.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    case (state_r)
      IDLE: begin
        if (en_r) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        count_next_s = preset_r;
        state_next_s = CNT;
      end
      CNT: begin
        if (!cnt_en_s) begin
          state_next_s = IDLE;
        end else if (count_r > 32'd1) begin
          count_next_s = count_r - 32'd1;
          state_next_s = CNT;
        end else begin
          count_next_s = 32'd0;
          state_next_s = INT;
        end
      end
      INT: begin
        if (reload_mode_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        count_next_s = 32'd0;
      end
    endcase
  end

  // CTRL fields: software writes win over the one-shot Enable clear in INT.
  always_comb begin
    im_next_s   = im_r;
    mode_next_s = mode_r;
    en_next_s   = en_r;
    if (ctrl_wr_s) begin
      im_next_s   = din[3];
      mode_next_s = din[2:1];
      en_next_s   = din[0];
    end else if ((state_r == INT) && !reload_mode_s) begin
      en_next_s   = 1'b0;
    end else begin
      en_next_s   = en_r;
    end
  end

  // PRESET is plain read/write storage; it only reaches COUNT through LOAD.
  always_comb begin
    preset_next_s = preset_r;
    if (preset_wr_s) begin
      preset_next_s = din;
    end else begin
      preset_next_s = preset_r;
    end
  end

  // Pending: any CTRL/PRESET write acknowledges; auto-reload drops it after one cycle.
  always_comb begin
    pending_next_s = pending_r;
    if (ctrl_wr_s || preset_wr_s) begin
      pending_next_s = 1'b0;
    end else if (expire_s) begin
      pending_next_s = 1'b1;
    end else if ((state_r == INT) && reload_mode_s) begin
      pending_next_s = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // State and register file update; reset overrides writes and FSM activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      im_r      <= 1'b0;
      mode_r    <= 2'b00;
      en_r      <= 1'b0;
      preset_r  <= 32'd0;
      count_r   <= 32'd0;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      im_r      <= im_next_s;
      mode_r    <= mode_next_s;
      en_r      <= en_next_s;
      preset_r  <= preset_next_s;
      count_r   <= count_next_s;
      pending_r <= pending_next_s;
    end
  end

  // Combinational read mux; reserved word and CTRL upper bits read as zero.
  always_comb begin
    dout = 32'd0;
    case (addr)
      ADDR_CTRL:   dout = {28'd0, im_r, mode_r, en_r};
      ADDR_PRESET: dout = preset_r;
      ADDR_COUNT:  dout = count_r;
      default:     dout = 32'd0;
    endcase
  end

  assign irq = pending_r & im_r;

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer with hand-computed expectations.
module tb_interval_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks = 0;
  int errors = 0;

  interval_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we   = 1'b1;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rl_cnt [12];

  initial begin
    rl_cnt = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
               32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3};
    reset = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_irq("rst_irq", 1'b0);
    chk_reg("rst_ctrl", 2'd0, 32'd0);
    chk_reg("rst_preset", 2'd1, 32'd0);
    chk_reg("rst_count", 2'd2, 32'd0);
    tick(1);
    chk_reg("rst_resv", 2'd3, 32'd0);

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    chk_reg("os_preset", 2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2);
    chk_reg("os_cnt_t2", 2'd2, 32'd5);
    tick(1); chk_reg("os_cnt_t3", 2'd2, 32'd4);
    tick(1); chk_reg("os_cnt_t4", 2'd2, 32'd3);
    tick(1); chk_reg("os_cnt_t5", 2'd2, 32'd2);
    tick(1); chk_reg("os_cnt_t6", 2'd2, 32'd1); chk_irq("os_irq_t6", 1'b0);
    tick(1); chk_reg("os_cnt_t7", 2'd2, 32'd0); chk_irq("os_irq_t7", 1'b1);
    tick(1); chk_reg("os_ctrl_t8", 2'd0, 32'h8); chk_irq("os_irq_t8", 1'b1);
    tick(3); chk_irq("os_irq_hold", 1'b1); chk_reg("os_cnt_hold", 2'd2, 32'd0);
    wr(2'd2, 32'd123);
    chk_reg("count_ro", 2'd2, 32'd0); chk_irq("count_wr_keeps_irq", 1'b1);

    wr(2'd0, 32'h8);
    chk_irq("ack_irq", 1'b0);
    tick(3); chk_reg("ack_cnt", 2'd2, 32'd0); chk_irq("ack_irq_idle", 1'b0);

    // Auto-reload, PRESET=3: pulses at t0+5, t0+10
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk_irq($sformatf("rl_irq_t%0d", k), (k == 5) || (k == 10));
      chk_reg($sformatf("rl_cnt_t%0d", k), 2'd2, rl_cnt[k-1]);
    end
    wr(2'd0, 32'h0);
    tick(3);
    chk_reg("rl_stop_cnt", 2'd2, 32'd3); chk_irq("rl_stop_irq", 1'b0);

    // PRESET write and IM change during CNT
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);
    tick(2); chk_reg("mid_cnt_t2", 2'd2, 32'd6);
    tick(1); chk_reg("mid_cnt_t3", 2'd2, 32'd5);
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    chk_reg("mid_cnt_t5", 2'd2, 32'd3);
    tick(1); chk_reg("mid_cnt_t6", 2'd2, 32'd2);
    tick(1); chk_irq("mid_irq_t7", 1'b0);
    tick(1); chk_irq("mid_irq_t8", 1'b1); chk_reg("mid_cnt_t8", 2'd2, 32'd0);
    chk_reg("mid_preset", 2'd1, 32'd20);
    tick(1); chk_reg("mid_ctrl_t9", 2'd0, 32'h8);
    wr(2'd0, 32'h8);

    // PRESET=0 behaves as 1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick(2); chk_reg("p0_cnt_t2", 2'd2, 32'd0); chk_irq("p0_irq_t2", 1'b0);
    tick(1); chk_irq("p0_irq_t3", 1'b1); chk_reg("p0_cnt_t3", 2'd2, 32'd0);
    tick(1); chk_reg("p0_cnt_t4", 2'd2, 32'd0); chk_reg("p0_ctrl_t4", 2'd0, 32'h8);
    wr(2'd0, 32'h8);

    // IM=0: expiry never raises irq
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick(11); chk_reg("im0_cnt_t11", 2'd2, 32'd1); chk_irq("im0_irq_t11", 1'b0);
    tick(1); chk_reg("im0_cnt_t12", 2'd2, 32'd0); chk_irq("im0_irq_t12", 1'b0);
    tick(1); chk_reg("im0_ctrl_t13", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk_irq("im0_irq_ack", 1'b0); chk_reg("im0_ctrl_ack", 2'd0, 32'h8);

    // Disable written on the final count edge
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick(3); chk_reg("race_cnt_t3", 2'd2, 32'd1);
    wr(2'd0, 32'h8);
    chk_irq("race_irq", 1'b0); chk_reg("race_cnt", 2'd2, 32'd1);
    chk_reg("race_ctrl", 2'd0, 32'h8);
    tick(3); chk_irq("race_irq_later", 1'b0); chk_reg("race_cnt_later", 2'd2, 32'd1);

    // CTRL write in INT re-enables a one-shot
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(3); chk_irq("int_irq_t3", 1'b1); chk_reg("int_cnt_t3", 2'd2, 32'd0);
    wr(2'd0, 32'h9);
    chk_irq("int_irq_t4", 1'b0); chk_reg("int_ctrl_t4", 2'd0, 32'h9);
    tick(2); chk_reg("int_cnt_t6", 2'd2, 32'd1); chk_irq("int_irq_t6", 1'b0);
    tick(1); chk_irq("int_irq_t7", 1'b1);
    tick(1); chk_reg("int_ctrl_t8", 2'd0, 32'h8);
    wr(2'd0, 32'h8);

    // Write masking on CTRL upper bits and reserved word
    wr(2'd0, 32'hFFFF_FFF0);
    chk_reg("ctrl_upper", 2'd0, 32'h0);
    wr(2'd3, 32'hDEAD_BEEF);
    chk_reg("resv_rd", 2'd3, 32'h0); chk_reg("resv_preset", 2'd1, 32'd1);

    // Reset mid-count with a concurrent write
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);
    tick(5); chk_reg("mrst_cnt_t5", 2'd2, 32'd6);
    @(negedge clk);
    reset = 1'b1; we = 1'b1; addr = 2'd1; din = 32'd77;
    @(posedge clk);
    #1;
    reset = 1'b0; we = 1'b0;
    chk_irq("mrst_irq", 1'b0);
    chk_reg("mrst_ctrl", 2'd0, 32'h0);
    chk_reg("mrst_preset", 2'd1, 32'd0);
    chk_reg("mrst_count", 2'd2, 32'd0);
    tick(20);
    chk_irq("mrst_irq_later", 1'b0); chk_reg("mrst_count_later", 2'd2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 SHALL have ports: clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port addr, input, 2, register word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-004 SHALL have port we, input, 1, write strobe, sampled at clk edge.
REQ-005 SHALL have port din, input, 32, write data.
REQ-006 SHALL have port dout, output, 32, combinational read data for addr.
REQ-007 SHALL have port irq, output, 1, interrupt request, level, driven to one CP0 HWInt bit.

Function
REQ-008 CTRL SHALL hold IM bit[3] (irq enable), Mode bits[2:1], Enable bit[0]; bits[31:4] SHALL ignore writes and read 0.
REQ-009 Mode 00 SHALL be one-shot; 01 SHALL be auto-reload; 10/11 SHALL behave as 00.
REQ-010 PRESET SHALL be 32-bit read/write; COUNT SHALL be 32-bit read-only (writes ignored).
REQ-011 dout SHALL be {28'b0, IM, Mode, Enable} / PRESET / COUNT / 0 for addr 0/1/2/3.
REQ-012 FSM states SHALL be IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if Enable=1 next state LOAD, else stay.
REQ-014 LOAD: COUNT <= PRESET; next state CNT.
REQ-015 CNT: Enable=0 -> IDLE, COUNT held; COUNT>1 -> COUNT-1, stay; COUNT<=1 -> COUNT<=0, pending<=1, next INT.
REQ-016 INT, mode 00: Enable<=0, next IDLE, pending held.
REQ-017 INT, mode 01: pending<=0, next LOAD (irq is a one-cycle pulse).
REQ-018 irq SHALL equal pending AND IM, combinational from registers.
REQ-019 Any write to CTRL or PRESET SHALL clear pending at that edge.
REQ-020 PRESET=0 SHALL behave as PRESET=1 (no underflow/wrap of COUNT).
REQ-021 Latency: from the edge writing Enable=1 (state IDLE), pending SHALL set at edge +PRESET+2 (PRESET>=1).
REQ-022 Auto-reload period SHALL be PRESET+2 cycles between irq pulses.
REQ-023 Write to PRESET during CNT SHALL not affect COUNT until next LOAD.
REQ-024 CTRL write keeping Enable=1 during CNT SHALL update IM/Mode only; counting continues.
REQ-025 CTRL write with Enable=0 in the same cycle CNT would enter INT: write wins, next IDLE, pending stays 0.
REQ-026 CTRL write in INT state: written Enable overrides the INT clear; FSM transition per REQ-016/017 still taken.
REQ-027 Mode-00 rearm SHALL require software writing Enable=1 again.

Reset
REQ-028 reset SHALL set CTRL=0, PRESET=0, COUNT=0, pending=0, state IDLE; irq=0, dout per addr from those values.
REQ-029 reset SHALL take priority over we and FSM activity, including mid-count and in INT.

Verification
REQ-030 PRESET=5, write CTRL=0x9 at edge t0 -> COUNT=5 at t0+2, COUNT 4,3,2,1 at t0+3..t0+6, COUNT=0 and irq=1 at t0+7, Enable reads 0 at t0+8, irq stays 1.
REQ-031 Continuation: write CTRL=0x8 -> irq=0 after that edge; COUNT stays 0, state IDLE.
REQ-032 PRESET=3, CTRL=0xB (mode 01, IM=1) -> irq one-cycle pulses every 5 cycles, COUNT reloads to 3 each period.
REQ-033 PRESET=0, CTRL=0x9 at t0 -> irq=1 at t0+3; COUNT never reads 0xFFFFFFFF.
REQ-034 PRESET=10, CTRL=0x1 (IM=0) -> pending sets at t0+12 but irq stays 0; write CTRL=0x8 -> irq still 0 (pending cleared).
REQ-035 Counting with COUNT=6, assert reset one cycle -> all registers 0, irq=0, no irq afterwards without new writes.
